// File: rtl/npc_unit.sv
// npc_unit: next-PC selection, program counter, run/halt control and
// program-flow statistics counters for the single-cycle CPU.
module npc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_J,
    input  logic             in_JW,
    input  logic             in_JR,
    input  logic             in_BEQ,
    input  logic             in_BNE,
    input  logic             in_BGEZ,
    input  logic             in_equal,
    input  logic [31:0]      in_rs,
    input  logic [15:0]      in_imm16,
    input  logic [25:0]      in_target26,
    input  logic             in_halt,
    input  logic             in_go,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc_plus4,
    output logic             out_taken,
    output logic             out_halted,
    output logic [CNT_W-1:0] out_cnt_cycle,
    output logic [CNT_W-1:0] out_cnt_jump,
    output logic [CNT_W-1:0] out_cnt_branch
);

    localparam int unsigned PC_W = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt_cycle;
    logic [CNT_W-1:0]  r_cnt_jump;
    logic [CNT_W-1:0]  r_cnt_branch;

    logic [PC_W-1:0]   w_seq;
    logic [PC_W-1:0]   w_br;
    logic [PC_W-1:0]   w_jt;
    logic [PC_W-1:0]   w_jr;
    logic [PC_W-1:0]   w_next_pc;
    logic              w_beq_taken;
    logic              w_bne_taken;
    logic              w_bgez_taken;
    logic              w_sel_jump;
    logic              w_sel_branch;
    logic              w_unused;

    // JR targets are word aligned, so the low rs bits never matter
    assign w_unused = ^in_rs[1:0];

    // Candidate targets, all wrapping modulo 2^32
    always_comb begin
        w_seq = r_pc + PC_W'(4);
        w_br  = w_seq + {{14{in_imm16[15]}}, in_imm16, 2'b00};
        w_jt  = {w_seq[31:28], in_target26, 2'b00};
        w_jr  = {in_rs[31:2], 2'b00};
    end

    // Conditional branch outcomes
    always_comb begin
        w_beq_taken  = in_BEQ  &  in_equal;
        w_bne_taken  = in_BNE  & ~in_equal;
        w_bgez_taken = in_BGEZ & ~in_rs[31];
    end

    // Next-PC priority select; halt blocks any redirect in the same cycle
    always_comb begin
        w_next_pc    = w_seq;
        w_sel_jump   = 1'b0;
        w_sel_branch = 1'b0;
        if (r_state == ST_RUN) begin
            if (in_halt) begin
                w_next_pc = r_pc;
            end else if (in_JR) begin
                w_next_pc  = w_jr;
                w_sel_jump = 1'b1;
            end else if (in_J || in_JW) begin
                w_next_pc  = w_jt;
                w_sel_jump = 1'b1;
            end else if (w_beq_taken || w_bne_taken || w_bgez_taken) begin
                w_next_pc    = w_br;
                w_sel_branch = 1'b1;
            end else begin
                w_next_pc = w_seq;
            end
        end else begin
            // Resume skips past the halt instruction
            w_next_pc = in_go ? w_seq : r_pc;
        end
    end

    // Run/halt state, program counter and saturating statistics counters
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= PC_RESET;
            r_cnt_cycle  <= '0;
            r_cnt_jump   <= '0;
            r_cnt_branch <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_pc <= w_next_pc;
                    if (r_cnt_cycle != {CNT_W{1'b1}}) begin
                        r_cnt_cycle <= r_cnt_cycle + CNT_W'(1);
                    end
                    if (w_sel_jump && (r_cnt_jump != {CNT_W{1'b1}})) begin
                        r_cnt_jump <= r_cnt_jump + CNT_W'(1);
                    end
                    if (w_sel_branch && (r_cnt_branch != {CNT_W{1'b1}})) begin
                        r_cnt_branch <= r_cnt_branch + CNT_W'(1);
                    end
                    if (in_halt) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (in_go) begin
                        r_state <= ST_RUN;
                        r_pc    <= w_next_pc;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign out_pc         = r_pc;
    assign out_pc_plus4   = w_seq;
    assign out_taken      = w_sel_jump | w_sel_branch;
    assign out_halted     = (r_state == ST_HALT);
    assign out_cnt_cycle  = r_cnt_cycle;
    assign out_cnt_jump   = r_cnt_jump;
    assign out_cnt_branch = r_cnt_branch;

endmodule

// File: tb/tb_npc_unit.sv
// Directed testbench for npc_unit with hand-computed expected values.
module tb_npc_unit;

    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             j, jw, jr, beq, bne, bgez, equal, halt, go;
    logic [31:0]      rs;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [31:0]      pc, pc_plus4;
    logic             taken, halted;
    logic [CNT_W-1:0] cnt_cycle, cnt_jump, cnt_branch;

    int n_cmp = 0;
    int n_err = 0;

    npc_unit #(.PC_RESET(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_J           (j),
        .in_JW          (jw),
        .in_JR          (jr),
        .in_BEQ         (beq),
        .in_BNE         (bne),
        .in_BGEZ        (bgez),
        .in_equal       (equal),
        .in_rs          (rs),
        .in_imm16       (imm16),
        .in_target26    (target26),
        .in_halt        (halt),
        .in_go          (go),
        .out_pc         (pc),
        .out_pc_plus4   (pc_plus4),
        .out_taken      (taken),
        .out_halted     (halted),
        .out_cnt_cycle  (cnt_cycle),
        .out_cnt_jump   (cnt_jump),
        .out_cnt_branch (cnt_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_strobes();
        j = 0; jw = 0; jr = 0; beq = 0; bne = 0; bgez = 0;
        equal = 0; halt = 0; go = 0;
        rs = '0; imm16 = '0; target26 = '0;
    endtask

    task automatic chk_cnt(input string tag, input int c, input int jmp, input int br);
        chk({tag, "_cyc"}, 32'(cnt_cycle),  32'(c));
        chk({tag, "_jmp"}, 32'(cnt_jump),   32'(jmp));
        chk({tag, "_br"},  32'(cnt_branch), 32'(br));
    endtask

    initial begin
        clr_strobes();
        rst_n = 0;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk_cnt("rst", 0, 0, 0);
        #10 rst_n = 1;

        // Sequential fetch after reset release
        tick(); chk("seq_pc1", pc, 32'h4);
        tick(); chk("seq_pc2", pc, 32'h8);
        tick(); chk("seq_pc3", pc, 32'hC);
        chk_cnt("seq", 3, 0, 0);

        // J to 0x0040_0010
        j = 1; target26 = 26'h010_0004; #1;
        chk("j_taken", 32'(taken), 32'h1);
        tick(); clr_strobes();
        chk("j_pc", pc, 32'h0040_0010);

        // BEQ taken with negative offset
        beq = 1; equal = 1; imm16 = 16'hFFFE; #1;
        chk("beq_taken", 32'(taken), 32'h1);
        tick();
        chk("beq_pc", pc, 32'h0040_000C);
        chk_cnt("beq", 5, 1, 1);

        // BEQ not taken, twice
        equal = 0; #1;
        chk("beq_nt_taken", 32'(taken), 32'h0);
        tick(); chk("beq_nt_pc1", pc, 32'h0040_0010);
        tick(); chk("beq_nt_pc2", pc, 32'h0040_0014);
        chk_cnt("beq_nt", 7, 1, 1);
        clr_strobes();

        // JR to 0x1000_0000, then JAL with link value check
        jr = 1; rs = 32'h1000_0000; tick(); clr_strobes();
        chk("jr_pc", pc, 32'h1000_0000);
        jw = 1; target26 = 26'h000_0123; #1;
        chk("jal_plus4", pc_plus4, 32'h1000_0004);
        chk("jal_taken", 32'(taken), 32'h1);
        tick(); clr_strobes();
        chk("jal_pc", pc, 32'h1000_048C);
        chk_cnt("jal", 9, 3, 1);

        // JR beats a taken BGEZ in the same cycle
        jr = 1; bgez = 1; rs = 32'h0000_2003; imm16 = 16'h0010;
        tick(); clr_strobes();
        chk("jr_bgez_pc", pc, 32'h0000_2000);
        chk_cnt("jr_bgez", 10, 4, 1);

        // BNE taken forward, then BGEZ not taken on negative rs
        bne = 1; equal = 0; imm16 = 16'h0004; tick(); clr_strobes();
        chk("bne_pc", pc, 32'h0000_2014);
        bgez = 1; rs = 32'h8000_0000; imm16 = 16'h0004; #1;
        chk("bgez_nt_taken", 32'(taken), 32'h0);
        tick(); clr_strobes();
        chk("bgez_nt_pc", pc, 32'h0000_2018);
        chk_cnt("bgez_nt", 12, 4, 2);

        // Move to 0x20, then halt with J and go also asserted
        j = 1; target26 = 26'h000_0008; tick(); clr_strobes();
        chk("j20_pc", pc, 32'h0000_0020);
        halt = 1; j = 1; target26 = 26'h000_0100; go = 1; #1;
        chk("halt_taken", 32'(taken), 32'h0);
        tick(); go = 0;
        chk("halt_pc", pc, 32'h0000_0020);
        chk("halt_halted", 32'(halted), 32'h1);
        chk_cnt("halt", 14, 5, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_pc", pc, 32'h0000_0020);
            chk("hold_halted", 32'(halted), 32'h1);
            chk("hold_taken", 32'(taken), 32'h0);
        end
        chk_cnt("hold", 14, 5, 2);

        // Resume skips the halt instruction
        clr_strobes(); go = 1; tick(); go = 0;
        chk("go_pc", pc, 32'h0000_0024);
        chk("go_halted", 32'(halted), 32'h0);
        chk_cnt("go", 14, 5, 2);
        tick();
        chk("run_pc", pc, 32'h0000_0028);
        chk_cnt("run", 15, 5, 2);

        // Asynchronous reset mid-HALT
        halt = 1; tick(); halt = 0;
        chk("halt2_halted", 32'(halted), 32'h1);
        #3 rst_n = 0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_halted", 32'(halted), 32'h0);
        chk_cnt("arst", 0, 0, 0);
        #3 rst_n = 1;

        // Cycle counter saturation
        for (int i = 0; i < 32'hFFFE; i++) tick();
        chk("sat_pre", 32'(cnt_cycle), 32'h0000_FFFE);
        tick(); tick(); tick();
        chk("sat_cyc", 32'(cnt_cycle), 32'h0000_FFFF);
        chk("sat_pc", pc, 32'h0004_0004);
        chk("sat_jmp", 32'(cnt_jump), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Next-PC and program-flow stage for the single-cycle CPU.
- Consumes the jump/branch decode strobes and the comparator results, and owns the program counter register.
- Selects each cycle's next PC: sequential, J/JAL, JR, or a taken BEQ/BNE/BGEZ.
- Implements the run/halt state for the halt syscall and keeps the CCMB statistics counters: total cycles, unconditional jumps, and taken conditional branches.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each statistics counter.

Ports:
- in_clk  input  1  system clock; all state updates on the rising edge.
- in_rst_n  input  1  reset; asynchronous assert, active-low.
- in_J  input  1  J instruction decoded.
- in_JW  input  1  JAL (jump and write link) decoded.
- in_JR  input  1  JR decoded.
- in_BEQ  input  1  BEQ decoded.
- in_BNE  input  1  BNE decoded.
- in_BGEZ  input  1  BGEZ decoded.
- in_equal  input  1  rs == rt comparator result.
- in_rs  input  32  rs register value, used as JR target and BGEZ sign.
- in_imm16  input  16  branch offset field, instr[15:0].
- in_target26  input  26  jump index field, instr[25:0].
- in_halt  input  1  halt syscall decoded this cycle.
- in_go  input  1  resume request; level-sensitive.
- out_pc  output  32  current PC, drives instruction memory address.
- out_pc_plus4  output  32  out_pc + 4, used as the JAL link value.
- out_taken  output  1  combinational; PC redirect occurs this cycle.
- out_halted  output  1  registered; high while in the HALT state.
- out_cnt_cycle  output  CNT_W  executed-cycle count.
- out_cnt_jump  output  CNT_W  unconditional jump count (J/JAL/JR).
- out_cnt_branch  output  CNT_W  taken conditional branch count.

Behaviour:
- Reset (in_rst_n low, asynchronous):
  - out_pc = PC_RESET; state = RUN; out_halted = 0; all counters = 0.
  - Takes effect immediately, including in HALT or mid-redirect; release is sampled at the next rising edge.
- Target computation, all 32-bit and wrapping mod 2^32:
  - seq = pc + 4.
  - br = seq + (sign-extended imm16 << 2).
  - jt = {seq[31:28], target26, 2'b00}.
  - jr = {in_rs[31:2], 2'b00}; the low bits are forced to 0.
- Conditional branch taken conditions:
  - BEQ: in_equal = 1.
  - BNE: in_equal = 0.
  - BGEZ: in_rs[31] = 0.
- Next-PC priority in RUN, highest first:
  1. in_halt: PC holds. No jump or branch is recorded even if a strobe is also high.
  2. in_JR: next = jr.
  3. in_J or in_JW: next = jt.
  4. BEQ taken, then BNE taken, then BGEZ taken: next = br.
  5. Otherwise: next = seq.
- out_taken = 1 exactly when case 2, 3 or 4 is selected. It is 0 in HALT.
- State machine, two states: RUN and HALT.
  - RUN with in_halt=1: go to HALT at the next edge. PC stays at the halt instruction. out_halted rises one cycle after the halt cycle.
  - HALT with in_go=0: stay in HALT. PC holds, counters hold, and all strobes and in_halt are ignored.
  - HALT with in_go=1: go to RUN and set PC = pc+4. The halt instruction is not re-executed.
  - in_go is ignored in RUN.
  - in_halt with in_go both high in RUN still enters HALT.
- Counters:
  - Update only in RUN cycles.
  - cnt_cycle increments on every RUN cycle, including the cycle that enters HALT.
  - cnt_jump increments in cases 2 and 3.
  - cnt_branch increments in case 4.
  - Not-taken branches are not counted.
  - Each counter saturates at all-ones and does not wrap.
- Latency:
  - PC updates one edge after the decode strobes are sampled.
  - out_pc_plus4 and out_taken are combinational from the current state and inputs.

Test Plan:
1. Reset then 3 idle RUN cycles -> out_pc 0,4,8,C; out_cnt_cycle=3; other counters 0.
2. At pc=0x0040_0010: BEQ, in_equal=1, imm16=0xFFFE -> next pc 0x0040_000C, cnt_branch=1. Repeat with in_equal=0 -> pc 0x0040_0014, cnt_branch unchanged.
3. At pc=0x1000_0000: in_JW=1, target26=0x0000123 -> next pc 0x1000_048C, out_pc_plus4=0x1000_0004 during the jump cycle, cnt_jump=1.
4. JR with in_rs=0x0000_2003 and BGEZ asserted together -> next pc 0x0000_2000 (JR wins), cnt_jump+1, cnt_branch unchanged.
5. in_halt at pc=0x20, in_go held 0 for 5 cycles -> out_pc stays 0x20, out_halted=1, counters frozen. Then in_go=1 for one cycle -> out_pc=0x24, out_halted=0.
6. Preload cnt_cycle to 0xFFFE and run 3 cycles -> cnt_cycle=0xFFFF, held. Separately, assert in_rst_n low mid-HALT -> out_pc=PC_RESET immediately, out_halted=0, counters 0.
